gonso_sequencer: RTL

//  Streams bytes out of port 1 of the 1RW1R SRAM on behalf of the register block.
//  It consumes the start, w_first, w_last and w_count configuration and produces
//  a valid/ready byte stream for the downstream bit serializer.
//  It drives the progress status back to the registers, whose progress falling edge raises irq.

---
 rtl/gonso_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gonso_sequencer.sv
// gonso_sequencer: streams bytes out of SRAM port 1 to the bit serializer.
// A start latches the window [first..last] and a pass count. Each byte is
// fetched (cs1_n low), captured one cycle later, then presented on a
// valid/ready interface. Addresses wrap modulo 2^ASIZE.
// Build option GONSO_SEQ_PREFETCH_EN: the handshake cycle issues the next
// read directly, skipping FETCH for every byte but the first.
module gonso_sequencer #(
  parameter int ASIZE = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             controller_en,
  input  logic             start,
  input  logic [3:0]       w_count,
  input  logic [ASIZE-1:0] w_first,
  input  logic [ASIZE-1:0] w_last,
  output logic             progress,
  output logic             done,
  output logic             cs1_n,
  output logic [ASIZE-1:0] addr1,
  input  logic [7:0]       rdata1,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  input  logic             byte_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t           state_q;
  logic [ASIZE-1:0] first_q;
  logic [ASIZE-1:0] last_q;
  logic [ASIZE-1:0] cur_q;
  logic [ASIZE-1:0] addr1_q;
  logic [3:0]       passes_q;
  logic             progress_q;
  logic             done_q;
  logic             cs1_n_q;
  logic             byte_valid_q;
  logic [7:0]       byte_data_q;

  logic             start_ok;
  logic             handshake;
  logic             at_last;
  logic             more_d;
  logic [ASIZE-1:0] cur_d;
  logic [3:0]       passes_d;

  // Decode start acceptance, the handshake and the address/pass that follow it.
  always_comb begin
    start_ok  = (state_q == IDLE) && start && controller_en && (w_count != 4'd0);
    handshake = (state_q == PRESENT) && byte_valid_q && byte_ready;
    at_last   = (cur_q == last_q);
    // Another byte follows unless this was the last address of the last pass.
    more_d    = !at_last || (passes_q > 4'd1);
    cur_d     = at_last ? first_q : (cur_q + ASIZE'(1));
    passes_d  = at_last ? (passes_q - 4'd1) : passes_q;
  end

  // Sequencer FSM with registered outputs; controller_en low aborts from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      first_q      <= '0;
      last_q       <= '0;
      cur_q        <= '0;
      addr1_q      <= '0;
      passes_q     <= 4'd0;
      progress_q   <= 1'b0;
      done_q       <= 1'b0;
      cs1_n_q      <= 1'b1;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (!controller_en) begin
        // Abort: a handshake in this cycle still completes on the serializer
        // side, but nothing further is fetched and no done pulse is produced.
        state_q      <= IDLE;
        progress_q   <= 1'b0;
        cs1_n_q      <= 1'b1;
        byte_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_ok) begin
              first_q    <= w_first;
              last_q     <= w_last;
              passes_q   <= w_count;
              cur_q      <= w_first;
              addr1_q    <= w_first;
              cs1_n_q    <= 1'b0;
              progress_q <= 1'b1;
              state_q    <= FETCH;
            end
          end
          FETCH: begin
            cs1_n_q <= 1'b1;
            state_q <= WAIT;
          end
          WAIT: begin
            byte_data_q  <= rdata1;
            byte_valid_q <= 1'b1;
            state_q      <= PRESENT;
          end
          PRESENT: begin
            if (handshake) begin
              byte_valid_q <= 1'b0;
              if (more_d) begin
                cur_q    <= cur_d;
                passes_q <= passes_d;
                addr1_q  <= cur_d;
`ifdef GONSO_SEQ_PREFETCH_EN
                // The read was already issued combinationally this cycle.
                state_q  <= WAIT;
`else
                cs1_n_q  <= 1'b0;
                state_q  <= FETCH;
`endif
              end else begin
                state_q    <= IDLE;
                progress_q <= 1'b0;
                done_q     <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef GONSO_SEQ_PREFETCH_EN
  // The next read overlaps the handshake cycle so rdata1 is ready in WAIT.
  // An abort in that cycle keeps the SRAM deselected.
  logic prefetch;
  assign prefetch = handshake && controller_en && more_d;
  assign cs1_n    = cs1_n_q & ~prefetch;
  assign addr1    = prefetch ? cur_d : addr1_q;
`else
  assign cs1_n    = cs1_n_q;
  assign addr1    = addr1_q;
`endif

  assign progress   = progress_q;
  assign done       = done_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;

endmodule
